secded_wr_encoder: RTL and testbench

//  Pipelined, parametrised SECDED write-path encoder between the AXI write datapath and the ECC SRAM.

---
 rtl/secded_pkg.sv | 60 ++++++
 rtl/secded_pipe_stage.sv | 51 +++++
 rtl/secded_wr_encoder.sv | 139 +++++++++++++
 tb/tb_secded_wr_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// ============================================================================
// secded_pkg : SECDED code-geometry helpers and the shared parity generator
// Rev 1.0
// ============================================================================
`default_nettype none

package secded_pkg;

  localparam int MAX_DATA_WIDTH  = 256;
  localparam int MAX_PARITY_BITS = 9;
  localparam int MAX_CODE_POS    = MAX_DATA_WIDTH + MAX_PARITY_BITS;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 14;

  typedef struct packed {
    logic                      ecc_en;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } enc_beat_t;

  function automatic int calc_parity_bits(input int dw);
    int p;
    p = 0;
    for (int q = 1; q < 31; q++) begin
      if (p == 0 && (1 << q) >= dw + q + 1) p = q;
    end
    return p;
  endfunction

  function automatic int calc_mem_data_width(input int dw);
    return dw + calc_parity_bits(dw) + 1;
  endfunction

  // Returns {parity[MAX_PARITY_BITS:1], overall}; data above dw must be zero.
  function automatic logic [MAX_PARITY_BITS:0] secded_encode(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input int                        dw
  );
    logic [MAX_PARITY_BITS:0] chk;
    int                       idx;
    chk = '0;
    idx = 0;
    for (int pos = 1; pos <= MAX_CODE_POS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (idx < dw) begin
          for (int k = 1; k <= MAX_PARITY_BITS; k++) begin
            if (pos[k-1]) chk[k] = chk[k] ^ data[idx];
          end
        end
        idx++;
      end
    end
    chk[0] = ^{chk[MAX_PARITY_BITS:1], data};
    return chk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/secded_pipe_stage.sv
// ============================================================================
// secded_pipe_stage : generic valid/ready register slice, full throughput
// Rev 1.0
// ============================================================================
`default_nettype none

module secded_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             w_adv;

  always_comb begin
    w_adv   = !valid_q || out_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    // Data only changes on a load, so a stalled beat stays stable.
    if (w_adv) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = w_adv;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/secded_wr_encoder.sv
// ============================================================================
// secded_wr_encoder : 2-stage SECDED write-path encoder with beat counter
// Optional one-shot error injection when ECC_ERR_INJECT_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module secded_wr_encoder
  import secded_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = 16,
  localparam int PARITY_BITS    = calc_parity_bits(DATA_WIDTH),
  localparam int MEM_DATA_WIDTH = calc_mem_data_width(DATA_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      ecc_en_i,
  input  logic [ADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ADDR_WIDTH-1:0]     wr_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] enc_data_o,
`ifdef ECC_ERR_INJECT_EN
  input  logic                      inj_arm_i,
  input  logic [MEM_DATA_WIDTH-1:0] inj_mask_i,
  output logic                      inj_done_o,
`endif
  output logic [CNT_WIDTH-1:0]      beat_cnt_o
);

  localparam int ADDR_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int S1_W       = 1 + ADDR_WIDTH + DATA_WIDTH;
`ifdef ECC_ERR_INJECT_EN
  localparam int S2_W       = 1 + ADDR_WIDTH + MEM_DATA_WIDTH;
`else
  localparam int S2_W       = ADDR_WIDTH + MEM_DATA_WIDTH;
`endif

  logic                      w_s1_in_ready;
  logic                      w_s1_valid;
  logic [S1_W-1:0]           w_s1_data;
  logic                      w_s2_in_ready;
  logic [S2_W-1:0]           w_s2_in;
  logic [S2_W-1:0]           w_s2_out;
  logic                      w_s1_ecc;
  logic [ADDR_WIDTH-1:0]     w_s1_addr;
  logic [DATA_WIDTH-1:0]     w_s1_dat;
  logic [MAX_DATA_WIDTH-1:0] w_data_ext;
  logic [PARITY_BITS:0]      w_chk;
  logic [MEM_DATA_WIDTH-1:0] w_enc;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  secded_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (w_s1_in_ready),
    .in_data_i   ({ecc_en_i, wr_addr_i >> ADDR_SHIFT, data_i}),
    .out_valid_o (w_s1_valid),
    .out_ready_i (w_s2_in_ready),
    .out_data_o  (w_s1_data)
  );

  always_comb begin
    {w_s1_ecc, w_s1_addr, w_s1_dat} = w_s1_data;
    w_data_ext                      = '0;
    w_data_ext[DATA_WIDTH-1:0]      = w_s1_dat;
    w_chk = w_s1_ecc ? (PARITY_BITS+1)'(secded_encode(w_data_ext, DATA_WIDTH)) : '0;
    w_enc = {w_chk, w_s1_dat};
  end

`ifdef ECC_ERR_INJECT_EN
  logic                      armed_q, armed_d;
  logic [MEM_DATA_WIDTH-1:0] mask_q,  mask_d;
  logic                      w_s2_load;
  logic                      w_s2_tag;

  always_comb begin
    w_s2_load = w_s1_valid && w_s2_in_ready;
    w_s2_in   = {armed_q, w_s1_addr, w_enc ^ (armed_q ? mask_q : '0)};
    armed_d   = armed_q;
    mask_d    = mask_q;
    if (w_s2_load) armed_d = 1'b0;
    // A fresh arm wins over the disarm caused by a same-cycle load.
    if (inj_arm_i) begin
      armed_d = 1'b1;
      mask_d  = inj_mask_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      armed_q <= armed_d;
      mask_q  <= mask_d;
    end
  end

  assign {w_s2_tag, wr_addr_o, enc_data_o} = w_s2_out;
  assign inj_done_o = out_valid_o && out_ready_i && w_s2_tag;
`else
  assign w_s2_in                 = {w_s1_addr, w_enc};
  assign {wr_addr_o, enc_data_o} = w_s2_out;
`endif

  secded_pipe_stage #(.WIDTH(S2_W)) u_s2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (w_s1_valid),
    .in_ready_o  (w_s2_in_ready),
    .in_data_i   (w_s2_in),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (w_s2_out)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_o && out_ready_i && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign in_ready_o = w_s1_in_ready;
  assign beat_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_secded_wr_encoder.sv
// ============================================================================
// tb_secded_wr_encoder : directed self-checking bench for secded_wr_encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_secded_wr_encoder;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int CW = 4;
  localparam int MW = 39;

  logic          clk;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          ecc_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [AW-1:0] wr_addr_o;
  logic [MW-1:0] enc_data_o;
  logic [CW-1:0] beat_cnt_o;
`ifdef ECC_ERR_INJECT_EN
  logic          inj_arm_i;
  logic [MW-1:0] inj_mask_i;
  logic          inj_done_o;
`endif

  int checks = 0;
  int errors = 0;

  secded_wr_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ecc_en_i    (ecc_en_i),
    .wr_addr_i   (wr_addr_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .wr_addr_o   (wr_addr_o),
    .enc_data_o  (enc_data_o),
`ifdef ECC_ERR_INJECT_EN
    .inj_arm_i   (inj_arm_i),
    .inj_mask_i  (inj_mask_i),
    .inj_done_o  (inj_done_o),
`endif
    .beat_cnt_o  (beat_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input string tag, input logic [DW-1:0] d, input logic e,
                       input logic [AW-1:0] a, input logic [MW-1:0] exp_enc,
                       input logic [AW-1:0] exp_a);
    in_valid_i = 1'b1;
    data_i     = d;
    ecc_en_i   = e;
    wr_addr_i  = a;
    step();
    in_valid_i = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid_o, 1'b0);
    step();
    chk({tag, "_valid"}, out_valid_o, 1'b1);
    chk({tag, "_enc"},   enc_data_o,  exp_enc);
    chk({tag, "_addr"},  wr_addr_o,   exp_a);
    step();
    chk({tag, "_drained"}, out_valid_o, 1'b0);
  endtask

  initial begin
    int acc;
    logic can_acc;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    ecc_en_i    = 1'b0;
    wr_addr_i   = '0;
    data_i      = '0;
    out_ready_i = 1'b1;
`ifdef ECC_ERR_INJECT_EN
    inj_arm_i   = 1'b0;
    inj_mask_i  = '0;
`endif
    step();
    step();
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready",  in_ready_o,  1'b1);
    chk("rst_enc",       enc_data_o,  39'h0);
    chk("rst_addr",      wr_addr_o,   14'h0);
    chk("rst_cnt",       beat_cnt_o,  4'h0);
    rst_i = 1'b0;
    step();

    send1("zero",    32'h0000_0000, 1'b1, 14'h0ABC, 39'h00_0000_0000, 14'h02AF);
    send1("single",  32'h0000_0001, 1'b1, 14'h0004, 39'h07_0000_0001, 14'h0001);
    send1("bypass",  32'hFFFF_FFFF, 1'b0, 14'h3FFF, 39'h00_FFFF_FFFF, 14'h0FFF);
    send1("ones",    32'hFFFF_FFFF, 1'b1, 14'h0010, 39'h30_FFFF_FFFF, 14'h0004);
    send1("msb",     32'h8000_0000, 1'b1, 14'h2000, 39'h4C_8000_0000, 14'h0800);
    chk("cnt_after_5", beat_cnt_o, 4'd5);

    // Backpressure: stream 1,2,3... with the memory side stalled for 5 cycles.
    out_ready_i = 1'b0;
    ecc_en_i    = 1'b1;
    wr_addr_i   = '0;
    in_valid_i  = 1'b1;
    data_i      = 32'd1;
    acc         = 0;
    for (int c = 1; c <= 5; c++) begin
      can_acc = in_ready_o;
      step();
      if (can_acc) begin
        acc++;
        data_i = data_i + 32'd1;
      end
      if (c >= 3) begin
        chk("stall_in_ready", in_ready_o,  1'b0);
        chk("stall_valid",    out_valid_o, 1'b1);
        chk("stall_enc",      enc_data_o,  39'h07_0000_0001);
      end
    end
    chk("stall_accepted", acc, 2);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    chk("release_2nd_valid", out_valid_o, 1'b1);
    chk("release_2nd_enc",   enc_data_o,  39'h0B_0000_0002);
    step();
    chk("release_empty", out_valid_o, 1'b0);
    chk("cnt_after_7",   beat_cnt_o,  4'd7);

    // Reset with both stages occupied.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    data_i      = 32'h55;
    step();
    data_i      = 32'h66;
    step();
    in_valid_i  = 1'b0;
    chk("full_valid", out_valid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", out_valid_o, 1'b0);
    chk("midrst_cnt",   beat_cnt_o,  4'd0);
    chk("midrst_enc",   enc_data_o,  39'h0);
    step();
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_no_stale", out_valid_o, 1'b0);
    end

    // Back-to-back stream with ECC bypassed: one beat per cycle.
    ecc_en_i   = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      in_valid_i = 1'b1;
      data_i     = 32'(j);
      chk("stream_in_ready", in_ready_o, 1'b1);
      step();
      if (j >= 2) chk("stream_enc", enc_data_o, 64'(j - 1));
    end
    in_valid_i = 1'b0;
    step();
    chk("stream_last", enc_data_o, 39'd10);
    step();
    chk("stream_empty", out_valid_o, 1'b0);
    chk("cnt_after_10", beat_cnt_o,  4'd10);

    // Ten more beats push the 4-bit counter past its limit.
    in_valid_i = 1'b1;
    for (int j = 0; j < 10; j++) begin
      data_i = 32'(100 + j);
      step();
    end
    in_valid_i = 1'b0;
    step();
    step();
    chk("cnt_saturated", beat_cnt_o, 4'hF);

`ifdef ECC_ERR_INJECT_EN
    inj_arm_i  = 1'b1;
    inj_mask_i = 39'h1;
    step();
    inj_arm_i  = 1'b0;
    ecc_en_i   = 1'b1;
    in_valid_i = 1'b1;
    data_i     = 32'h0;
    step();
    in_valid_i = 1'b0;
    step();
    chk("inj_enc",  enc_data_o, 39'h1);
    chk("inj_done", inj_done_o, 1'b1);
    step();
    chk("inj_done_pulse", inj_done_o, 1'b0);
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    chk("inj_oneshot_enc",  enc_data_o, 39'h0);
    chk("inj_oneshot_done", inj_done_o, 1'b0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
